// File: rtl/core_local_interruptor_pkg.sv
// ----------------------------------------------------------------------------
// core_local_interruptor_pkg
// Shared definitions for the core-local interruptor (CLINT):
//   - byte offsets of the memory-mapped registers
//   - handshake FSM state encoding
//   - reset value of mtimecmp
//   - byte-lane merge helper used for all 32-bit register writes
// ----------------------------------------------------------------------------
package core_local_interruptor_pkg;

    localparam logic [31:0] MsipOffset       = 32'h00;
    localparam logic [31:0] SsipOffset       = 32'h04;
    localparam logic [31:0] MtimecmpLoOffset = 32'h08;
    localparam logic [31:0] MtimecmpHiOffset = 32'h0C;
    localparam logic [31:0] MtimeLoOffset    = 32'h10;
    localparam logic [31:0] MtimeHiOffset    = 32'h14;

    // All ones so the CSR unit's mtime >= mtimecmp test cannot fire after reset.
    localparam logic [63:0] MtimecmpReset = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        Idle = 1'b0,
        Ack  = 1'b1
    } clint_state_t;

    // Replace each byte of old_word whose enable is set with the matching byte of new_word.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  byte_en
    );
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// ----------------------------------------------------------------------------
// clint_prescaler
// Free-running counter 0..PRESCALER-1; o_tick is high during the cycle in
// which the counter sits at PRESCALER-1, i.e. the edge that ends that cycle
// is the mtime increment edge. PRESCALER=1 gives a tick every cycle.
// Legal PRESCALER range is 1..65535.
// Ports:
//   clock   system clock
//   reset   asynchronous active-high reset (counter returns to 0)
//   o_tick  mtime increment enable
// ----------------------------------------------------------------------------
module clint_prescaler #(
    parameter int unsigned PRESCALER = 1
) (
    input  logic clock,
    input  logic reset,
    output logic o_tick
);

    logic [15:0] r_count;
    logic        w_wrap;

    assign w_wrap = (r_count == 16'(PRESCALER - 1));
    assign o_tick = w_wrap;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule

// File: rtl/core_local_interruptor.sv
// ----------------------------------------------------------------------------
// core_local_interruptor
// Memory-mapped CLINT holding msip, ssip, the 64-bit mtime counter and the
// 64-bit mtimecmp compare value. Feeds the CSR unit's mem_msip, mem_ssip,
// mem_mtime and mem_mtimecmp inputs; the timer-interrupt compare itself
// lives in the CSR unit.
// Ports:
//   clock, reset            clock and asynchronous active-high reset
//   i_rd_en / i_wr_en       request strobes, held until o_ack
//   i_addr                  byte offset (bits [1:0] ignored)
//   i_wr_data, i_byte_en    write data and per-byte write enables
//   o_rd_data               read data (pre-write contents), valid with o_ack
//   o_ack                   one-cycle completion pulse
//   o_msip, o_ssip          software interrupt pending bits
//   o_mtime, o_mtimecmp     timer and compare registers (registered outputs)
// ----------------------------------------------------------------------------
module core_local_interruptor
    import core_local_interruptor_pkg::*;
#(
    parameter int unsigned PRESCALER = 1,
    parameter int unsigned ADDR_SIZE = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_rd_en,
    input  logic                 i_wr_en,
    input  logic [ADDR_SIZE-1:0] i_addr,
    input  logic [31:0]          i_wr_data,
    input  logic [3:0]           i_byte_en,
    output logic [31:0]          o_rd_data,
    output logic                 o_ack,
    output logic                 o_msip,
    output logic                 o_ssip,
    output logic [63:0]          o_mtime,
    output logic [63:0]          o_mtimecmp
);

    clint_state_t r_state;
    logic         r_ack;
    logic [31:0]  r_rd_data;
    logic         r_msip;
    logic         r_ssip;
    logic [63:0]  r_mtime;
    logic [63:0]  r_mtimecmp;

    logic         w_tick;
    logic [31:0]  w_offset;
    logic         w_accept;
    logic         w_write;
    logic [31:0]  w_read_word;
    logic [63:0]  w_mtime_next;
    logic [63:0]  w_mtimecmp_next;
    logic         w_msip_next;
    logic         w_ssip_next;

    clint_prescaler #(
        .PRESCALER (PRESCALER)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .o_tick (w_tick)
    );

    // Word-aligned offset; the low two address bits never select anything.
    assign w_offset = 32'(i_addr) & ~32'h3;

    // Only Idle accepts; a request still high during Ack waits for the next Idle.
    // A simultaneous read and write is served as a write.
    assign w_accept = (r_state == Idle) && (i_rd_en || i_wr_en);
    assign w_write  = w_accept && i_wr_en;

    always_comb begin
        w_read_word = '0;
        case (w_offset)
            MsipOffset:       w_read_word = {31'd0, r_msip};
            SsipOffset:       w_read_word = {31'd0, r_ssip};
            MtimecmpLoOffset: w_read_word = r_mtimecmp[31:0];
            MtimecmpHiOffset: w_read_word = r_mtimecmp[63:32];
            MtimeLoOffset:    w_read_word = r_mtime[31:0];
            MtimeHiOffset:    w_read_word = r_mtime[63:32];
            default:          w_read_word = '0;
        endcase
    end

    always_comb begin
        w_msip_next     = r_msip;
        w_ssip_next     = r_ssip;
        w_mtimecmp_next = r_mtimecmp;
        if (w_write) begin
            case (w_offset)
                MsipOffset:       if (i_byte_en[0]) w_msip_next = i_wr_data[0];
                SsipOffset:       if (i_byte_en[0]) w_ssip_next = i_wr_data[0];
                MtimecmpLoOffset: w_mtimecmp_next[31:0]  = merge_bytes(r_mtimecmp[31:0],  i_wr_data, i_byte_en);
                MtimecmpHiOffset: w_mtimecmp_next[63:32] = merge_bytes(r_mtimecmp[63:32], i_wr_data, i_byte_en);
                default:          ;
            endcase
        end
    end

    // A write that touches mtime replaces the tick for that cycle: the written
    // half takes the bus bytes over its old contents, the other half stays put
    // and no carry is propagated. Otherwise a tick is one full 64-bit add.
    always_comb begin
        w_mtime_next = r_mtime;
        if (w_write && (|i_byte_en) && (w_offset == MtimeLoOffset)) begin
            w_mtime_next[31:0] = merge_bytes(r_mtime[31:0], i_wr_data, i_byte_en);
        end else if (w_write && (|i_byte_en) && (w_offset == MtimeHiOffset)) begin
            w_mtime_next[63:32] = merge_bytes(r_mtime[63:32], i_wr_data, i_byte_en);
        end else if (w_tick) begin
            w_mtime_next = r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= Idle;
            r_ack      <= 1'b0;
            r_rd_data  <= '0;
            r_msip     <= 1'b0;
            r_ssip     <= 1'b0;
            r_mtime    <= '0;
            r_mtimecmp <= MtimecmpReset;
        end else begin
            r_msip     <= w_msip_next;
            r_ssip     <= w_ssip_next;
            r_mtime    <= w_mtime_next;
            r_mtimecmp <= w_mtimecmp_next;
            case (r_state)
                Idle: begin
                    r_ack <= 1'b0;
                    if (w_accept) begin
                        r_state   <= Ack;
                        r_ack     <= 1'b1;
                        r_rd_data <= w_read_word;
                    end
                end
                Ack: begin
                    r_state <= Idle;
                    r_ack   <= 1'b0;
                end
                default: begin
                    r_state <= Idle;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_ack      = r_ack;
    assign o_msip     = r_msip;
    assign o_ssip     = r_ssip;
    assign o_mtime    = r_mtime;
    assign o_mtimecmp = r_mtimecmp;

endmodule

// File: tb/tb_core_local_interruptor.sv
// ----------------------------------------------------------------------------
// tb_core_local_interruptor
// Bench for the CLINT: a PRESCALER=1 instance carries all bus traffic, a
// PRESCALER=4 instance with an idle bus checks the timer rate. Expected read
// data is queued when a request is issued and popped when its ack arrives.
// ----------------------------------------------------------------------------
module tb_core_local_interruptor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  byte_en = '0;
    logic [31:0] rd_data;
    logic        ack;
    logic        msip;
    logic        ssip;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    logic        rd_en4 = 1'b0;
    logic        wr_en4 = 1'b0;
    logic [4:0]  addr4 = '0;
    logic [31:0] wr_data4 = '0;
    logic [3:0]  byte_en4 = '0;
    logic [31:0] rd_data4;
    logic        ack4;
    logic        msip4;
    logic        ssip4;
    logic [63:0] mtime4;
    logic [63:0] mtimecmp4;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int unsigned cyc = 0;

    localparam logic [63:0] AllOnes = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clock = ~clock;

    // Posedges since reset was released; both instances share this reset.
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    core_local_interruptor #(.PRESCALER(1), .ADDR_SIZE(5)) dut (
        .clock(clock), .reset(reset),
        .i_rd_en(rd_en), .i_wr_en(wr_en), .i_addr(addr),
        .i_wr_data(wr_data), .i_byte_en(byte_en),
        .o_rd_data(rd_data), .o_ack(ack),
        .o_msip(msip), .o_ssip(ssip),
        .o_mtime(mtime), .o_mtimecmp(mtimecmp)
    );

    core_local_interruptor #(.PRESCALER(4), .ADDR_SIZE(5)) dut4 (
        .clock(clock), .reset(reset),
        .i_rd_en(rd_en4), .i_wr_en(wr_en4), .i_addr(addr4),
        .i_wr_data(wr_data4), .i_byte_en(byte_en4),
        .o_rd_data(rd_data4), .o_ack(ack4),
        .o_msip(msip4), .o_ssip(ssip4),
        .o_mtime(mtime4), .o_mtimecmp(mtimecmp4)
    );

    // Drive one request from a falling edge, hold it until ack (bounded), drop it.
    // Returns at the falling edge where ack was seen.
    task automatic do_access(input logic rd, input logic wr, input logic [4:0] a,
                             input logic [31:0] d, input logic [3:0] be,
                             output logic [31:0] got, output bit ok);
        @(negedge clock);
        rd_en = rd; wr_en = wr; addr = a; wr_data = d; byte_en = be;
        ok = 1'b0;
        got = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (ack === 1'b1) begin
                ok = 1'b1;
                got = rd_data;
                break;
            end
        end
        rd_en = 1'b0; wr_en = 1'b0;
        $display("access rd=%0b wr=%0b addr=%02h data=%08h be=%04b -> ack=%0b rd_data=%08h",
                 rd, wr, a, d, be, ok, got);
    endtask

    task automatic test_reset();
        logic [31:0] got;
        logic [31:0] exp_v;
        bit          ok;
        logic [4:0]  a_tab [3];
        logic [31:0] e_tab [3];
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (ack !== 1'b0 || ack4 !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0b/%0b exp=0", ack, ack4); end
        checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%08h exp=00000000", rd_data); end
        checks++; if (msip !== 1'b0 || ssip !== 1'b0) begin failures++; $display("FAIL reset_sip got=%0b%0b exp=00", msip, ssip); end
        checks++; if (mtimecmp !== AllOnes) begin failures++; $display("FAIL reset_mtimecmp got=%016h exp=%016h", mtimecmp, AllOnes); end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mtime !== 64'(k)) begin failures++; $display("FAIL mtime_count_%0d got=%016h exp=%016h", k, mtime, 64'(k)); end
            @(negedge clock);
        end
        a_tab = '{5'h08, 5'h0C, 5'h00};
        e_tab = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(e_tab[i]);
            do_access(1'b1, 1'b0, a_tab[i], 32'h0, 4'h0, got, ok);
            exp_v = exp_q.pop_front();
            checks++;
            if (!ok) begin failures++; $display("FAIL reset_read_%02h no ack within bound", a_tab[i]); end
            else if (got !== exp_v) begin failures++; $display("FAIL reset_read_%02h got=%08h exp=%08h", a_tab[i], got, exp_v); end
        end
    endtask

    task automatic test_soft_irq();
        logic [31:0] got;
        logic [31:0] exp_v;
        bit          ok;
        logic        rd_t [9];
        logic        wr_t [9];
        logic [4:0]  a_t  [9];
        logic [31:0] d_t  [9];
        logic [3:0]  be_t [9];
        logic [31:0] e_t  [9];
        logic        m_t  [9];
        logic        s_t  [9];
        rd_t = '{0, 1, 0, 0, 1, 1, 1, 0, 1};
        wr_t = '{1, 0, 1, 1, 0, 1, 0, 1, 0};
        a_t  = '{5'h00, 5'h00, 5'h04, 5'h00, 5'h04, 5'h04, 5'h18, 5'h1C, 5'h1C};
        d_t  = '{32'h3, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
        be_t = '{4'b0001, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 4'b0001, 4'b0000, 4'b1111, 4'b0000};
        e_t  = '{32'h0, 32'h1, 32'h0, 32'h1, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0};
        m_t  = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        s_t  = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(e_t[i]);
            do_access(rd_t[i], wr_t[i], a_t[i], d_t[i], be_t[i], got, ok);
            exp_v = exp_q.pop_front();
            checks++;
            if (!ok) begin failures++; $display("FAIL sip_op%0d no ack within bound", i); end
            else if (got !== exp_v) begin failures++; $display("FAIL sip_op%0d rd_data got=%08h exp=%08h", i, got, exp_v); end
            checks++;
            if (msip !== m_t[i] || ssip !== s_t[i]) begin
                failures++; $display("FAIL sip_op%0d bits got msip=%0b ssip=%0b exp msip=%0b ssip=%0b", i, msip, ssip, m_t[i], s_t[i]);
            end
        end
    endtask

    task automatic test_mtimecmp();
        logic [31:0] got;
        logic [31:0] exp_v;
        bit          ok;
        exp_q.push_back(32'hFFFF_FFFF);
        do_access(1'b0, 1'b1, 5'h08, 32'h1234_5678, 4'b0011, got, ok);
        exp_v = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp_v) begin failures++; $display("FAIL cmp_write ack=%0b got=%08h exp=%08h", ok, got, exp_v); end
        checks++;
        if (mtimecmp !== 64'hFFFF_FFFF_FFFF_5678) begin failures++; $display("FAIL cmp_value got=%016h exp=FFFFFFFFFFFF5678", mtimecmp); end
        exp_q.push_back(32'hFFFF_5678);
        do_access(1'b1, 1'b0, 5'h08, 32'h0, 4'h0, got, ok);
        exp_v = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp_v) begin failures++; $display("FAIL cmp_read ack=%0b got=%08h exp=%08h", ok, got, exp_v); end
    endtask

    task automatic test_mtime_carry();
        logic [31:0] got;
        bit          ok;
        logic [31:0] hi_t [2];
        logic [63:0] at_t [2];
        logic [63:0] nx_t [2];
        hi_t = '{32'h0, 32'hFFFF_FFFF};
        at_t = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        nx_t = '{64'h0000_0001_0000_0000, 64'h0};
        for (int i = 0; i < 2; i++) begin
            do_access(1'b0, 1'b1, 5'h14, hi_t[i], 4'hF, got, ok);
            checks++; if (!ok) begin failures++; $display("FAIL carry%0d_hi no ack within bound", i); end
            do_access(1'b0, 1'b1, 5'h10, 32'hFFFF_FFFF, 4'hF, got, ok);
            checks++;
            if (!ok || mtime !== at_t[i]) begin failures++; $display("FAIL carry%0d_write ack=%0b got=%016h exp=%016h", i, ok, mtime, at_t[i]); end
            @(negedge clock);
            checks++;
            if (mtime !== nx_t[i]) begin failures++; $display("FAIL carry%0d_tick got=%016h exp=%016h", i, mtime, nx_t[i]); end
        end
    endtask

    task automatic test_write_on_tick();
        logic [31:0] got;
        bit          ok;
        do_access(1'b0, 1'b1, 5'h14, 32'h5, 4'hF, got, ok);
        checks++; if (!ok) begin failures++; $display("FAIL tick_hi no ack within bound"); end
        do_access(1'b0, 1'b1, 5'h10, 32'h10, 4'hF, got, ok);
        checks++;
        if (!ok || mtime !== 64'h0000_0005_0000_0010) begin failures++; $display("FAIL tick_write ack=%0b got=%016h exp=0000000500000010", ok, mtime); end
        @(negedge clock);
        checks++;
        if (mtime !== 64'h0000_0005_0000_0011) begin failures++; $display("FAIL tick_after got=%016h exp=0000000500000011", mtime); end
    endtask

    task automatic test_prescaler();
        int          changes;
        logic [63:0] prev;
        logic [63:0] exp_m;
        changes = 0;
        @(negedge clock);
        prev = mtime4;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            exp_m = 64'(cyc / 4);
            checks++;
            if (mtime4 !== exp_m) begin failures++; $display("FAIL presc_cycle%0d got=%016h exp=%016h", k, mtime4, exp_m); end
            if (mtime4 !== prev) changes++;
            prev = mtime4;
        end
        checks++;
        if (changes != 10) begin failures++; $display("FAIL presc_increments got=%0d exp=10", changes); end
        $display("prescaler=4 increments in 40 cycles: %0d", changes);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_v;
        int          acks;
        logic [31:0] got;
        bit          ok;
        acks = 0;
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h3);
        @(negedge clock);
        wr_en = 1'b1; rd_en = 1'b0; addr = 5'h0C; byte_en = 4'hF; wr_data = 32'h1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            checks++;
            if (ack !== logic'(k % 2)) begin failures++; $display("FAIL b2b_ack_cycle%0d got=%0b exp=%0b", k, ack, k % 2); end
            if (ack === 1'b1) begin
                acks++;
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                checks++;
                if (rd_data !== exp_v) begin failures++; $display("FAIL b2b_rd_data%0d got=%08h exp=%08h", k, rd_data, exp_v); end
                $display("b2b ack at cycle %0d rd_data=%08h", k, rd_data);
            end
            wr_data = 32'(k + 1);
        end
        wr_en = 1'b0;
        checks++;
        if (acks != 3 || exp_q.size() != 0) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=3 leftover=%0d", acks, exp_q.size()); end
        checks++;
        if (mtimecmp[63:32] !== 32'h5) begin failures++; $display("FAIL b2b_final got=%08h exp=00000005", mtimecmp[63:32]); end

        // Reset while ack is high.
        @(negedge clock);
        wr_en = 1'b1; addr = 5'h08; wr_data = 32'h0; byte_en = 4'hF;
        @(negedge clock);
        checks++;
        if (ack !== 1'b1) begin failures++; $display("FAIL rst_ack_pre got=%0b exp=1", ack); end
        reset = 1'b1;
        #1;
        wr_en = 1'b0;
        checks++;
        if (ack !== 1'b0 || msip !== 1'b0 || mtime !== 64'h0 || rd_data !== 32'h0) begin
            failures++; $display("FAIL rst_mid ack=%0b msip=%0b mtime=%016h rd_data=%08h exp 0/0/0/0", ack, msip, mtime, rd_data);
        end
        checks++;
        if (mtimecmp !== AllOnes) begin failures++; $display("FAIL rst_mid_cmp got=%016h exp=%016h", mtimecmp, AllOnes); end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_q.push_back(32'hFFFF_FFFF);
        do_access(1'b1, 1'b0, 5'h08, 32'h0, 4'h0, got, ok);
        exp_v = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp_v) begin failures++; $display("FAIL rst_read ack=%0b got=%08h exp=%08h", ok, got, exp_v); end
    endtask

    initial begin
        test_reset();
        test_soft_irq();
        test_mtimecmp();
        test_mtime_carry();
        test_write_on_tick();
        test_prescaler();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
